instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Consumer end of the program-counter path. Accepts fetch addresses from the PC unit, reads 32-bit instruction words from instruction memory over a one-outstanding-request interface, and buffers each returned word with its PC in a FIFO for the decode stage. A flush input discards all queued and in-flight fetches when the PC unit takes a branch (`Branch & Zero` or `Uncondbranch`).

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc_in  in  32  fetch address from PC unit
- pc_valid  in  1  pc_in is valid
- pc_ready  out  1  queue accepts pc_in this cycle
- flush  in  1  branch redirect; discard queued and in-flight fetches
- mem_req  out  1  read strobe to instruction memory, one cycle
- mem_addr  out  32  read address, word aligned
- mem_rdata  in  32  returned instruction word
- mem_rvalid  in  1  mem_rdata valid; exactly one per mem_req, never the same cycle as the req
- inst_out  out  32  head instruction word
- inst_pc  out  32  PC of head instruction
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  decode consumes head
- align_err  out  1  sticky: a misaligned PC was accepted

## Operation
- States: IDLE (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
- pc_ready = !reset & state==IDLE & count<DEPTH & !flush.
- Accept (pc_valid & pc_ready): mem_req=1, mem_addr={pc_in[31:2],2'b00} in the same cycle, combinationally. Register pc_in as the pending tag. IDLE→WAIT.
- mem_req=0 and mem_addr=0 whenever no accept occurs.
- WAIT & mem_rvalid & !flush: push {pending tag, mem_rdata}. WAIT→IDLE.
- WAIT & flush, no mem_rvalid: WAIT→DROP. WAIT & flush & mem_rvalid: discard the word. WAIT→IDLE.
- DROP & mem_rvalid: discard. DROP→IDLE. flush in DROP: stay in DROP.
- Pop: inst_valid & inst_ready & !flush advances the read pointer.
- Push and pop in the same cycle leave count unchanged. Push into a full FIFO cannot occur, because accept requires count<DEPTH.
- flush: read pointer, write pointer and count go to 0 next cycle. flush overrides any same-cycle push and pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- pc_in[1:0]!=0 on accept: the fetch proceeds with the aligned address and the tag keeps the raw pc_in. align_err is set and stays set until reset.
- inst_out and inst_pc show the head entry while inst_valid=1, and 0 when the FIFO is empty.

## Timing
- Reset (synchronous, while high): state=IDLE, pointers=0, count=0, align_err=0. Outputs are inst_valid=0, inst_out=0, inst_pc=0, mem_req=0, mem_addr=0, pc_ready=0.
- Reset mid-WAIT returns the state to IDLE. A later stray mem_rvalid arriving in IDLE is ignored.
- Latency: accept at cycle t, mem_rvalid at t+k (k≥1), inst_valid at t+k+1.
- Next accept is possible at t+k+1, giving a throughput of one fetch per k+1 cycles.
- inst_valid deasserts the cycle after the last entry pops.
- flush at cycle f gives inst_valid=0 at f+1. A new accept is possible at f+1 if the state is IDLE.

## Test plan
- Basic fetch: pc_in=0x100, memory k=1 returns 0x8B020020. Required: mem_addr=0x100 at t, inst_valid=1 at t+2 with inst_out=0x8B020020, inst_pc=0x100.
- Fill with inst_ready=0, DEPTH=4, PCs 0x0, 0x4, 0x8, 0xC. Required: pc_ready=0 after the 4th push. Then pop one; the next accept is 0x10, and pops return the order 0x0, 0x4, 0x8, 0xC, 0x10.
- Flush in WAIT: accept 0x20, flush at t+1, mem_rvalid at t+3 with 0xDEADBEEF. Required: the word is never visible and inst_valid stays 0. pc_ready=1 at t+4. Next fetch 0x40 returns normally.
- Flush coincident with mem_rvalid and a pop, with 2 entries queued. Required: FIFO empty next cycle, state IDLE, no entry pushed.
- Misaligned: pc_in=0x102. Required: mem_addr=0x100, inst_pc=0x102, align_err=1 held until reset.
- Reset mid-operation: assert reset while 3 entries are queued and a request is outstanding. Required: all outputs 0 next cycle. A stray mem_rvalid after reset is ignored and count stays 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one-outstanding instruction-memory reads for
// accepted PCs and buffers each returned word with its PC for decode.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        align_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     tag_q, tag_d;
  logic            align_err_q, align_err_d;

  logic [31:0]     data_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;

  // Handshake and memory request are purely combinational so the read
  // issues in the same cycle the PC is accepted.
  always_comb begin
    pc_ready = !reset && (state_q == IDLE) && (count_q < DEPTH_C) && !flush;
    accept   = pc_valid && pc_ready;
    mem_req  = accept;
    mem_addr = accept ? {pc_in[31:2], 2'b00} : 32'd0;
  end

  always_comb begin
    inst_valid = (count_q != '0);
    inst_out   = inst_valid ? data_mem[rd_ptr_q] : 32'd0;
    inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'd0;
    align_err  = align_err_q;
  end

  assign push = (state_q == WAIT) && mem_rvalid && !flush;
  assign pop  = inst_valid && inst_ready && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        // A response arriving with the flush is simply dropped here.
        if (mem_rvalid)  state_d = IDLE;
        else if (flush)  state_d = DROP;
      end
      DROP: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_d       = tag_q;
    align_err_d = align_err_q;
    if (accept) begin
      tag_d = pc_in;
      if (pc_in[1:0] != 2'b00) align_err_d = 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      tag_q       <= 32'd0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      align_err_q <= align_err_d;
    end
  end

  // Storage needs no reset; entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      data_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]   <= tag_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4).
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        align_err;

  int checks = 0;
  int passed = 0;

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Accept pc, return data one cycle later; leaves the bench in the cycle
  // where the pushed entry is visible and the queue is IDLE again.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    pc_valid = 1'b1;
    pc_in    = pc;
    #1;
    chk("fetch_req", {31'd0, mem_req}, 32'd1);
    tick();
    pc_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    #1;
    $display("fetch pc=0x%08h data=0x%08h", pc, data);
  endtask

  task automatic pop_one();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_in = 32'h100; pc_valid = 1'b1; flush = 1'b0;
    mem_rdata = 32'd0; mem_rvalid = 1'b0; inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    reset = 1'b0; pc_valid = 1'b0;
    tick();

    // Basic fetch with k=1
    pc_valid = 1'b1; pc_in = 32'h100;
    #1;
    chk("basic_ready", {31'd0, pc_ready}, 32'd1);
    chk("basic_req", {31'd0, mem_req}, 32'd1);
    chk("basic_addr", mem_addr, 32'h100);
    tick();
    pc_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8B020020;
    #1;
    chk("basic_wait_ready", {31'd0, pc_ready}, 32'd0);
    chk("basic_wait_valid", {31'd0, inst_valid}, 32'd0);
    chk("basic_idle_addr", mem_addr, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("basic_valid", {31'd0, inst_valid}, 32'd1);
    chk("basic_out", inst_out, 32'h8B020020);
    chk("basic_pc", inst_pc, 32'h100);
    pop_one();
    chk("basic_empty", {31'd0, inst_valid}, 32'd0);
    chk("basic_empty_out", inst_out, 32'd0);

    // Fill to DEPTH, then pop one and refill with wrap
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'hA000_0000 + 32'(i * 4));
    pc_valid = 1'b1; pc_in = 32'h10;
    #1;
    chk("full_ready", {31'd0, pc_ready}, 32'd0);
    chk("full_req", {31'd0, mem_req}, 32'd0);
    chk("full_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("refill_ready", {31'd0, pc_ready}, 32'd1);
    chk("refill_addr", mem_addr, 32'h10);
    tick();
    pc_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0010;
    tick();
    mem_rvalid = 1'b0;
    #1;
    for (int i = 1; i < 5; i++) begin
      chk("order_pc", inst_pc, 32'(i * 4));
      chk("order_out", inst_out, 32'hA000_0000 + 32'(i * 4));
      pop_one();
    end
    chk("order_empty", {31'd0, inst_valid}, 32'd0);

    // Flush while a request is outstanding
    pc_valid = 1'b1; pc_in = 32'h20;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flw_ready_f", {31'd0, pc_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flw_drop_ready", {31'd0, pc_ready}, 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("flw_drop_ready2", {31'd0, pc_ready}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("flw_dropped", {31'd0, inst_valid}, 32'd0);
    chk("flw_ready_t4", {31'd0, pc_ready}, 32'd1);
    fetch(32'h40, 32'h1111_0040);
    chk("flw_next_pc", inst_pc, 32'h40);
    chk("flw_next_out", inst_out, 32'h1111_0040);
    pop_one();

    // Flush coincident with rvalid and pop, two entries queued
    fetch(32'h50, 32'h5555_0050);
    fetch(32'h54, 32'h5555_0054);
    pc_valid = 1'b1; pc_in = 32'h58;
    tick();
    pc_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_0058;
    flush = 1'b1; inst_ready = 1'b1;
    tick();
    mem_rvalid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    #1;
    chk("flc_empty", {31'd0, inst_valid}, 32'd0);
    chk("flc_idle", {31'd0, pc_ready}, 32'd1);
    chk("flc_out", inst_out, 32'd0);
    tick();
    chk("flc_no_push", {31'd0, inst_valid}, 32'd0);

    // Misaligned PC
    pc_valid = 1'b1; pc_in = 32'h102;
    #1;
    chk("mis_addr", mem_addr, 32'h100);
    tick();
    pc_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_0102;
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("mis_pc", inst_pc, 32'h102);
    chk("mis_out", inst_out, 32'h2222_0102);
    chk("mis_err", {31'd0, align_err}, 32'd1);
    pop_one();
    fetch(32'h60, 32'h6666_0060);
    chk("mis_err_held", {31'd0, align_err}, 32'd1);
    pop_one();

    // Reset with 3 queued and one outstanding
    fetch(32'h70, 32'h7777_0070);
    fetch(32'h74, 32'h7777_0074);
    fetch(32'h78, 32'h7777_0078);
    pc_valid = 1'b1; pc_in = 32'h7C;
    tick();
    pc_valid = 1'b0; reset = 1'b1;
    tick();
    #1;
    chk("mrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mrst_out", inst_out, 32'd0);
    chk("mrst_pc", inst_pc, 32'd0);
    chk("mrst_err", {31'd0, align_err}, 32'd0);
    chk("mrst_ready", {31'd0, pc_ready}, 32'd0);
    chk("mrst_req", {31'd0, mem_req}, 32'd0);
    chk("mrst_addr", mem_addr, 32'd0);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("mrst_idle", {31'd0, pc_ready}, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("stray_ignored", {31'd0, inst_valid}, 32'd0);
    fetch(32'h80, 32'h8888_0080);
    chk("post_rst_pc", inst_pc, 32'h80);
    chk("post_rst_out", inst_out, 32'h8888_0080);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
